dff_pipe: RTL

- Parametrised successor to the team's 4-bit enabled D register.
- WIDTH-bit data travels through a DEPTH-stage elastic register pipeline with valid/ready handshakes at both ends.
- Adds a programmable reset value, global enable (freeze), synchronous flush and an occupancy count.
- Used wherever a registered, back-pressurable delay line is needed between datapath blocks.

---
 rtl/dff_pipe.sv | 98 +++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshakes at both ends.
// Adds a programmable reset value, a global freeze (en), a synchronous flush and an occupancy count.
module dff_pipe #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int RESET_VAL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              CW    = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_xfer;

    // A stage can load when any stage at or downstream of it is empty, or the sink drains.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!vld_q[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = en && !flush && rdy[0];
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush) begin
            vld_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RST_V;
            end
        end else if (en) begin
            if (rdy[0]) begin
                vld_d[0] = in_xfer;
                if (in_xfer) begin
                    data_d[0] = d;
                end
            end
            // Bubbles keep their stale data so q stays stable while out_valid is low.
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(vld_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_V;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid = en && vld_q[DEPTH-1];
    assign q         = data_q[DEPTH-1];
    assign count     = count_q;

endmodule
